code_sender: RTL and testbench

- Initiator side of the keypad code-lock interface: on a button press, drives a programmable 3-digit code onto the 4-bit digit bus that feeds the lock checker.
- Then waits for the checker's 8-bit unlock status and reports pass/fail.
- Sits upstream of the checker FSM; used as an auto-dialer and as the self-test stimulus source on the lab board.

---
 rtl/code_sender_if.sv | 21 ++
 rtl/code_sender.sv | 153 +++++++++++++++
 tb/tb_code_sender.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/code_sender_if.sv
// Digit bus between the code sender and the lock checker, together with the
// start button and the unlock status that comes back from the checker.
interface code_sender_if;
    logic       btn;
    logic [7:0] lock_status;
    logic [3:0] data_out;
    logic       digit_valid;
    logic       busy;
    logic       done;
    logic       pass;

    modport master (
        input  btn, lock_status,
        output data_out, digit_valid, busy, done, pass
    );

    modport slave (
        output btn, lock_status,
        input  data_out, digit_valid, busy, done, pass
    );
endinterface

// File: rtl/code_sender.sv
// Code-lock initiator: on a button press, sends three digits onto the checker bus.
// It then waits a bounded time for the unlock status and reports pass or fail.
module code_sender #(
    parameter logic [3:0] DIGIT0  = 4'h3,
    parameter logic [3:0] DIGIT1  = 4'h1,
    parameter logic [3:0] DIGIT2  = 4'h4,
    parameter int         HOLD    = 4,
    parameter int         GAP     = 2,
    parameter int         TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    code_sender_if.master bus
);

    localparam int CMAX = (HOLD > GAP) ? ((HOLD > TIMEOUT) ? HOLD : TIMEOUT)
                                       : ((GAP > TIMEOUT) ? GAP : TIMEOUT);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_GAP, ST_WAIT, ST_DONE} state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          btn_d;
    logic [3:0]    data_q, data_n;
    logic          valid_q, valid_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          pass_q, pass_n;
    logic          start;
    logic          unlocked;

    function automatic logic [3:0] digit(input logic [1:0] i);
        case (i)
            2'd0:    digit = DIGIT0;
            2'd1:    digit = DIGIT1;
            default: digit = DIGIT2;
        endcase
    endfunction

    assign start    = bus.btn && !btn_d;
    assign unlocked = (bus.lock_status == 8'hFF);

    // btn_d resets high so a button already held at reset release is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cnt     <= '0;
            btn_d   <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            btn_d   <= bus.btn;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        data_n  = data_q;
        valid_n = valid_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pass_n  = pass_q;
        case (state)
            ST_IDLE: begin
                data_n  = '0;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    state_n = ST_SEND;
                    idx_n   = '0;
                    cnt_n   = '0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    data_n  = DIGIT0;
                    valid_n = 1'b1;
                end
            end
            ST_SEND: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n = '0;
                    if (idx == 2'd2) begin
                        state_n = ST_WAIT;
                        data_n  = '0;
                        valid_n = 1'b0;
                    end else if (GAP == 0) begin
                        idx_n  = idx + 2'd1;
                        data_n = digit(idx + 2'd1);
                    end else begin
                        state_n = ST_GAP;
                        data_n  = '0;
                        valid_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_SEND;
                    idx_n   = idx + 2'd1;
                    cnt_n   = '0;
                    data_n  = digit(idx + 2'd1);
                    valid_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                // An unlock seen on the last timeout cycle still counts as a pass.
                if (unlocked || cnt == TO_LAST) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    pass_n  = unlocked;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.data_out    = data_q;
    assign bus.digit_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: default timing, early unlock, reset cases,
// a behavioural lock checker for integration, and the back-to-back variant.
module tb_code_sender;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n;
    logic use_chk;
    logic [7:0] ls0, ls2;
    logic [3:0] exp_bus [16] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'h1, 4'h1,
                                 4'h1, 4'h1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};

    always #5 clk = ~clk;

    code_sender_if if0 ();
    code_sender_if if1 ();
    code_sender_if if2 ();

    code_sender u0 (.clk(clk), .rst(rst), .bus(if0));
    code_sender #(.DIGIT1(4'h2)) u1 (.clk(clk), .rst(rst), .bus(if1));
    code_sender #(.HOLD(1), .GAP(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

    // Lock checker model: collects one digit per valid burst, unlocks on 3,1,4.
    logic [11:0] sh0, sh1;
    logic [2:0]  n0, n1;
    logic        vp0, vp1;
    logic [7:0]  chk0, chk1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh0 <= '0; n0 <= '0; vp0 <= 1'b0; chk0 <= '0;
        end else begin
            vp0 <= if0.digit_valid;
            if (if0.done) begin
                sh0 <= '0; n0 <= '0; chk0 <= '0;
            end else begin
                if (if0.digit_valid && !vp0) begin
                    sh0 <= {sh0[7:0], if0.data_out};
                    n0  <= n0 + 3'd1;
                end
                if (!if0.digit_valid && vp0 && n0 == 3'd3 && sh0 == 12'h314) chk0 <= 8'hFF;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh1 <= '0; n1 <= '0; vp1 <= 1'b0; chk1 <= '0;
        end else begin
            vp1 <= if1.digit_valid;
            if (if1.done) begin
                sh1 <= '0; n1 <= '0; chk1 <= '0;
            end else begin
                if (if1.digit_valid && !vp1) begin
                    sh1 <= {sh1[7:0], if1.data_out};
                    n1  <= n1 + 3'd1;
                end
                if (!if1.digit_valid && vp1 && n1 == 3'd3 && sh1 == 12'h314) chk1 <= 8'hFF;
            end
        end
    end

    assign if0.lock_status = use_chk ? chk0 : ls0;
    assign if1.lock_status = chk1;
    assign if2.lock_status = ls2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; use_chk = 1'b0; ls0 = '0; ls2 = '0;
        if0.btn = 1'b1; if1.btn = 1'b0; if2.btn = 1'b0;
        #12;
        chk("rst data", if0.data_out, 0);
        chk("rst valid", if0.digit_valid, 0);
        chk("rst busy", if0.busy, 0);
        chk("rst done", if0.done, 0);
        chk("rst pass", if0.pass, 0);

        // Button held through reset release must not start a send.
        tick(); rst = 1'b0;
        repeat (5) tick();
        chk("held busy", if0.busy, 0);
        chk("held valid", if0.digit_valid, 0);
        if0.btn = 1'b0;
        repeat (2) tick();

        // Early unlock, with a second press during SEND that must be ignored.
        if0.btn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) chk("p1 busy", if0.busy, 1);
            chk("p1 data", if0.data_out, exp_bus[i]);
            chk("p1 valid", if0.digit_valid, exp_bus[i] != 0);
            if (i == 4) if0.btn = 1'b0;
            if (i == 6) if0.btn = 1'b1;
            if (i == 9) if0.btn = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("p1 wait busy", if0.busy, 1);
            chk("p1 wait done", if0.done, 0);
        end
        ls0 = 8'hFF;
        tick();
        chk("p1 done", if0.done, 1);
        chk("p1 busy drop", if0.busy, 0);
        chk("p1 pass", if0.pass, 1);
        ls0 = 8'h00;
        tick();
        chk("p1 done pulse", if0.done, 0);
        repeat (3) tick();
        chk("p1 pass hold", if0.pass, 1);

        // New press clears pass, then runs to timeout.
        if0.btn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) chk("p2 pass clr", if0.pass, 0);
            chk("p2 data", if0.data_out, exp_bus[i]);
            chk("p2 valid", if0.digit_valid, exp_bus[i] != 0);
            if (i == 2) if0.btn = 1'b0;
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) begin
                chk("p2 last wait busy", if0.busy, 1);
                chk("p2 last wait done", if0.done, 0);
            end
        end
        tick();
        chk("p2 done", if0.done, 1);
        chk("p2 pass", if0.pass, 0);
        chk("p2 busy", if0.busy, 0);
        tick();
        chk("p2 done pulse", if0.done, 0);

        // Asynchronous reset in the middle of the second digit.
        if0.btn = 1'b1;
        repeat (7) tick();
        chk("mid data", if0.data_out, 4'h1);
        if0.btn = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst data", if0.data_out, 0);
        chk("arst busy", if0.busy, 0);
        chk("arst valid", if0.digit_valid, 0);
        tick(); rst = 1'b0;
        repeat (2) tick();
        if0.btn = 1'b1;
        tick();
        chk("restart data", if0.data_out, 4'h3);
        chk("restart valid", if0.digit_valid, 1);
        if0.btn = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; repeat (2) tick();

        // Integration with the checker model, correct code.
        use_chk = 1'b1;
        if0.btn = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick(); n++;
            if (i == 1) if0.btn = 1'b0;
            if (if0.done) break;
        end
        chk("int ok lat", n, 19);
        chk("int ok lock", chk0, 8'hFF);
        chk("int ok pass", if0.pass, 1);

        // Integration, wrong second digit: checker stays locked.
        if1.btn = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick(); n++;
            if (i == 1) if1.btn = 1'b0;
            if (if1.done) break;
        end
        chk("int bad lat", n, 33);
        chk("int bad lock", chk1, 0);
        chk("int bad pass", if1.pass, 0);

        // Back-to-back digits, unlock on the final timeout cycle.
        if2.btn = 1'b1;
        tick();
        chk("b2b d0", if2.data_out, 4'h3);
        chk("b2b v0", if2.digit_valid, 1);
        if2.btn = 1'b0;
        tick();
        chk("b2b d1", if2.data_out, 4'h1);
        chk("b2b v1", if2.digit_valid, 1);
        tick();
        chk("b2b d2", if2.data_out, 4'h4);
        chk("b2b v2", if2.digit_valid, 1);
        tick();
        chk("b2b idle data", if2.data_out, 0);
        chk("b2b idle valid", if2.digit_valid, 0);
        for (int k = 5; k <= 19; k++) tick();
        chk("b2b last busy", if2.busy, 1);
        chk("b2b last done", if2.done, 0);
        ls2 = 8'hFF;
        tick();
        chk("b2b done", if2.done, 1);
        chk("b2b pass", if2.pass, 1);
        ls2 = 8'h00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
